data_memory_port: RTL
=====================

# data_memory_port

Parametrised, synthesizable data-memory slave for the Riscv core's load/store path, replacing the combinational DataMemory with a valid/ready request/response port of configurable read latency. Supports RISC-V sub-word accesses with byte lanes and sign extension, plus address range checking. Sits between the core's load/store unit and a word-organised storage array owned by this block.

## Interface
- ADDR_WIDTH, 32, width of req_addr
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two, ≥4)
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0 (word-aligned)
- READ_LATENCY, 1, cycles from request acceptance to rsp_valid (1..15)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_addr  in  ADDR_WIDTH  byte address
- req_write  in  1  1 = store, 0 = load
- req_size  in  3  RISC-V funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu)
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  load result, sign/zero-extended; 0 for stores and errors
- rsp_err  out  1  access rejected (range, size, or alignment)

## Operation
- FSM states: IDLE, WAIT, RESP. One outstanding request.
- IDLE: req_ready=1. On req_valid at a rising edge: accept, decode, commit store, capture load data; go to RESP if READ_LATENCY=1, else WAIT with counter loaded READ_LATENCY-1.
- WAIT: req_ready=0; decrement counter each cycle; at 1 go to RESP.
- RESP: rsp_valid=1, rsp_rdata/rsp_err stable; on rsp_ready go IDLE. Held indefinitely while rsp_ready=0.
- Offset = req_addr − BASE_ADDR (ADDR_WIDTH bits, unsigned wrap). Out of range when offset ≥ DEPTH_WORDS*4 (covers addr < BASE_ADDR via wrap) → rsp_err=1.
- Word index = offset[log2(DEPTH_WORDS)+1:2]; byte lane = offset[1:0].
- Loads: b/bu select lane byte, h/hu select offset[1] half; b/h sign-extend, bu/hu zero-extend, w whole word.
- Stores: only sizes 000/001/010 legal; write only the addressed byte/half lanes from req_wdata[7:0]/[15:0]; other lanes untouched.
- Illegal size (loads 011/110/111, stores anything but 000–010) → rsp_err=1, no write.
- Any error: no array write, rsp_rdata=0.
- Load data is sampled at the acceptance edge; later stores cannot alter an in-flight response.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE, counter=0. Array contents not reset.
- Accept at edge N → rsp_valid rises after edge N+READ_LATENCY.
- Store takes effect at edge N; a load accepted at the next acceptance reads the new data.
- Minimum request spacing READ_LATENCY+1 cycles (response handshake cycle included); no acceptance in WAIT or RESP.
- rsp_ready asserted before rsp_valid has no effect; rsp_ready and rsp_valid high at edge M → rsp_valid=0 and req_ready=1 after M.
- Reset mid-WAIT/RESP: FSM to IDLE immediately, pending response discarded; a store already accepted remains committed.

## Configuration
- DATA_MEMORY_PORT_MISALIGN_TRAP_EN defined: half access with offset[0]≠0 or word access with offset[1:0]≠0 → rsp_err=1, no write, rsp_rdata=0.
- Undefined: alignment bits ignored — halves use offset[1] only, words ignore offset[1:0]; rsp_err only for range/size errors.

## Test plan
- READ_LATENCY=1: sw 7 to 0x8, then lw 0x8 → rsp_rdata=32'h7, rsp_err=0, rsp_valid one cycle after each acceptance.
- Sub-word: sw 32'h8081_F0FF to 0x10; lb 0x10 → FFFF_FFFF; lbu 0x11 → 0000_00F0; lh 0x12 → FFFF_8081; lhu 0x12 → 0000_8081; sb 0x55 to 0x13 then lw → 5581_F0FF.
- READ_LATENCY=4 with rsp_ready held low 3 extra cycles: rsp_valid rises 4 cycles after accept, data stable, req_ready=0 throughout until handshake.
- Range: DEPTH_WORDS=16, lw 0x40 and lw BASE_ADDR−4 → rsp_err=1, rdata 0; store to 0x40 leaves word 0 unchanged.
- Alignment: lw 0x6 → with macro rsp_err=1; without, returns word at 0x4.
- Reset asserted in WAIT after sw 9 to 0x0: rsp_valid never rises, req_ready=1 after release, lw 0x0 → 9.

Source files
------------

// File: rtl/data_memory_port.sv
// rtl/data_memory_port.sv - valid/ready data-memory slave with sub-word access and configurable read latency
// Optional: DATA_MEMORY_PORT_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module data_memory_port #(
  parameter int          ADDR_WIDTH   = 32,
  parameter int          DEPTH_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [2:0]            req_size,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [ADDR_WIDTH-1:0] offset;
  logic [IDX_W-1:0]      word_idx;
  logic [1:0]            lane;
  logic                  in_range, size_ok, misalign, req_err, accept, wr_en;
  logic [31:0]           word, load_val, wr_data;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [3:0]            byte_en;

  // Subtraction wraps, so addresses below BASE_ADDR land far out of range.
  assign offset   = req_addr - BASE_A;
  assign in_range = (offset >> (IDX_W + 2)) == '0;
  assign word_idx = offset[IDX_W+1:2];
  assign lane     = offset[1:0];

  assign size_ok = req_write ? (req_size inside {3'b000, 3'b001, 3'b010})
                             : (req_size inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});

`ifdef DATA_MEMORY_PORT_MISALIGN_TRAP_EN
  assign misalign = ((req_size[1:0] == 2'b01) && offset[0]) ||
                    ((req_size[1:0] == 2'b10) && (offset[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_err = !in_range || !size_ok || misalign;
  assign accept  = (state_q == IDLE) && req_valid;
  assign wr_en   = accept && req_write && !req_err;

  assign word     = mem_q[word_idx];
  assign byte_sel = 8'(word >> {lane, 3'b000});
  assign half_sel = offset[1] ? word[31:16] : word[15:0];

  always_comb begin
    load_val = '0;
    case (req_size)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_val = {24'b0, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_val = {16'b0, half_sel};
      3'b010:  load_val = word;
      default: load_val = '0;
    endcase
  end

  always_comb begin
    byte_en = 4'b0000;
    wr_data = req_wdata;
    case (req_size[1:0])
      2'b00: begin
        byte_en = 4'b0001 << lane;
        wr_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        byte_en = offset[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{req_wdata[15:0]}};
      end
      default: byte_en = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem_q[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Response data is captured at acceptance so later stores cannot disturb it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          err_d   = req_err;
          rdata_d = (req_write || req_err) ? 32'h0 : load_val;
          if (READ_LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
